// File: rtl/fp32_pkg.sv
// Shared FP32 constants, sequencer state encoding and operand classification
// types for the sequential FP32 multiplier.
package fp32_pkg;

  localparam int FP_WIDTH   = 32;
  localparam int EXP_WIDTH  = 8;
  localparam int MANT_WIDTH = 23;
  localparam int BIAS       = 127;

  localparam logic [FP_WIDTH-1:0] QNAN = 32'h7FC0_0000;

  // out_flags = {invalid, overflow, underflow, inexact}
  localparam int FLAG_W         = 4;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXP  = 3'd1,
    MANT = 3'd2,
    NORM = 3'd3,
    DONE = 3'd4
  } fp_state_e;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_class_t;

  function automatic logic [FP_WIDTH-1:0] fp_pack(
    input logic                  sign,
    input logic [EXP_WIDTH-1:0]  exp,
    input logic [MANT_WIDTH-1:0] mant
  );
    return {sign, exp, mant};
  endfunction

endpackage

// File: rtl/fp_mul_special_detect.sv
// Combinational classification of one FP32 operand (sign bit excluded).
// Denormals are reported as zero so the multiplier flushes them.
module fp_mul_special_detect
  import fp32_pkg::*;
(
  input  logic [FP_WIDTH-2:0] i_op,
  output fp_class_t           o_class
);

  logic [EXP_WIDTH-1:0]  w_exp;
  logic [MANT_WIDTH-1:0] w_frac;

  assign w_exp  = i_op[FP_WIDTH-2 -: EXP_WIDTH];
  assign w_frac = i_op[MANT_WIDTH-1:0];

  always_comb begin
    o_class         = '0;
    o_class.is_zero = (w_exp == '0);
    o_class.is_inf  = (&w_exp) && (w_frac == '0);
    o_class.is_nan  = (&w_exp) && (w_frac != '0);
  end

endmodule

// File: rtl/fp_mul_seq_ctrl.sv
// Sequential FP32 multiplier: one operation in flight, fixed 26-cycle latency
// from accept to out_valid (EXP, 24 shift-add MANT cycles, NORM).
module fp_mul_seq_ctrl #(
  parameter int FP_WIDTH   = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23,
  parameter int BIAS       = 127
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP_WIDTH-1:0] in_a,
  input  logic [FP_WIDTH-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FP_WIDTH-1:0] out_result,
  output logic [3:0]          out_flags,
  output logic                busy
);

  import fp32_pkg::fp_state_e;
  import fp32_pkg::fp_class_t;
  import fp32_pkg::IDLE;
  import fp32_pkg::EXP;
  import fp32_pkg::MANT;
  import fp32_pkg::NORM;
  import fp32_pkg::DONE;
  import fp32_pkg::QNAN;
  import fp32_pkg::FLAG_INVALID;
  import fp32_pkg::FLAG_OVERFLOW;
  import fp32_pkg::FLAG_UNDERFLOW;
  import fp32_pkg::FLAG_INEXACT;
  import fp32_pkg::fp_pack;

  localparam int SIG_W  = MANT_WIDTH + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int ESUM_W = EXP_WIDTH + 2;
  localparam int CNT_W  = $clog2(SIG_W);

  localparam logic [CNT_W-1:0]         LAST_ITER = CNT_W'(SIG_W - 1);
  localparam logic signed [ESUM_W-1:0] EXP_OVF   = ESUM_W'((2 ** EXP_WIDTH) - 1);
  localparam logic [EXP_WIDTH-1:0]     EXP_ONES  = '1;

  fp_state_e r_state, w_state_next;

  logic [FP_WIDTH-1:0]   r_a, r_b;
  logic                  r_sign;
  logic [ESUM_W-1:0]     r_esum;
  fp_class_t             r_cls_a, r_cls_b, w_cls_a, w_cls_b;
  logic [SIG_W-1:0]      r_mcand, r_mplier;
  logic [PROD_W-1:0]     r_prod;
  logic [CNT_W-1:0]      r_cnt;
  logic [FP_WIDTH-1:0]   r_result;
  logic [3:0]            r_flags;

  logic                  w_accept;
  logic                  w_last_iter;
  logic [PROD_W-1:0]     w_addend;
  logic                  w_hi;
  logic [MANT_WIDTH-1:0] w_mant;
  logic                  w_lost;
  logic [ESUM_W-1:0]     w_exp_norm;
  logic [FP_WIDTH-1:0]   w_result;
  logic [3:0]            w_flags;

  fp_mul_special_detect u_detect_a (
    .i_op    (r_a[FP_WIDTH-2:0]),
    .o_class (w_cls_a)
  );

  fp_mul_special_detect u_detect_b (
    .i_op    (r_b[FP_WIDTH-2:0]),
    .o_class (w_cls_b)
  );

  assign w_accept    = in_valid && (r_state == IDLE);
  assign w_last_iter = (r_cnt == LAST_ITER);
  assign w_addend    = PROD_W'(r_mcand) << r_cnt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)    w_state_next = EXP;
      EXP:                      w_state_next = MANT;
      MANT:    if (w_last_iter) w_state_next = NORM;
      NORM:                     w_state_next = DONE;
      DONE:    if (out_ready)   w_state_next = IDLE;
      default:                  w_state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_result = r_result;
  assign out_flags  = r_flags;

  // Normalisation, truncation and special-case packing
  always_comb begin
    w_hi       = r_prod[PROD_W-1];
    w_mant     = w_hi ? r_prod[PROD_W-2 -: MANT_WIDTH] : r_prod[PROD_W-3 -: MANT_WIDTH];
    w_lost     = w_hi ? (|r_prod[SIG_W-1:0]) : (|r_prod[SIG_W-2:0]);
    w_exp_norm = r_esum + ESUM_W'(w_hi);
    w_result   = fp_pack(r_sign, w_exp_norm[EXP_WIDTH-1:0], w_mant);
    w_flags    = '0;
    w_flags[FLAG_INEXACT] = w_lost;

    if (r_cls_a.is_nan || r_cls_b.is_nan ||
        (r_cls_a.is_inf && r_cls_b.is_zero) || (r_cls_a.is_zero && r_cls_b.is_inf)) begin
      w_result = QNAN;
      w_flags  = '0;
      w_flags[FLAG_INVALID] = 1'b1;
    end else if (r_cls_a.is_inf || r_cls_b.is_inf) begin
      w_result = fp_pack(r_sign, EXP_ONES, '0);
      w_flags  = '0;
    end else if (r_cls_a.is_zero || r_cls_b.is_zero) begin
      w_result = fp_pack(r_sign, '0, '0);
      w_flags  = '0;
    end else if ($signed(w_exp_norm) >= EXP_OVF) begin
      w_result = fp_pack(r_sign, EXP_ONES, '0);
      w_flags  = '0;
      w_flags[FLAG_OVERFLOW] = 1'b1;
      w_flags[FLAG_INEXACT]  = 1'b1;
    end else if ($signed(w_exp_norm) <= 0) begin
      w_result = fp_pack(r_sign, '0, '0);
      w_flags  = '0;
      w_flags[FLAG_UNDERFLOW] = 1'b1;
      w_flags[FLAG_INEXACT]   = 1'b1;
    end
  end

  // Operand capture and shift-add datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sign   <= 1'b0;
      r_esum   <= '0;
      r_cls_a  <= '0;
      r_cls_b  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a <= in_a;
            r_b <= in_b;
          end
        end
        EXP: begin
          r_sign   <= r_a[FP_WIDTH-1] ^ r_b[FP_WIDTH-1];
          r_esum   <= ESUM_W'(r_a[FP_WIDTH-2 -: EXP_WIDTH]) +
                      ESUM_W'(r_b[FP_WIDTH-2 -: EXP_WIDTH]) - ESUM_W'(BIAS);
          r_cls_a  <= w_cls_a;
          r_cls_b  <= w_cls_b;
          r_mcand  <= {1'b1, r_a[MANT_WIDTH-1:0]};
          r_mplier <= {1'b1, r_b[MANT_WIDTH-1:0]};
          r_prod   <= '0;
          r_cnt    <= '0;
        end
        MANT: begin
          if (r_mplier[0]) begin
            r_prod <= r_prod + w_addend;
          end
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        NORM: begin
          r_result <= w_result;
          r_flags  <= w_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
// Directed-vector bench for the sequential FP32 multiplier, with hand-written
// backpressure and mid-operation reset sequences.
module tb_fp_mul_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  localparam int LATENCY = 26;
  localparam int TIMEOUT = 60;

  fp_mul_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Wait for out_valid after an accept edge; returns number of edges elapsed.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < TIMEOUT) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [3:0] flg);
    int cycles;
    @(negedge clk);
    check({name, ".in_ready"}, 32'(in_ready), 32'd1);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({name, ".busy"}, 32'(busy), 32'd1);
    wait_valid(cycles);
    check({name, ".latency"}, 32'(cycles), 32'(LATENCY));
    check({name, ".result"}, out_result, res);
    check({name, ".flags"}, 32'(out_flags), 32'(flg));
    $display("op %-12s a=%h b=%h -> result=%h flags=%b latency=%0d",
             name, a, b, out_result, out_flags, cycles);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, ".out_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int cycles;
    int seen_valid;

    // name, a, b, expected result, expected {invalid,overflow,underflow,inexact}
    vecs[0]  = '{"1.5x2",      32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[1]  = '{"3x3",        32'h40400000, 32'h40400000, 32'h41100000, 4'b0000};
    vecs[2]  = '{"ovf",        32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101};
    vecs[3]  = '{"unf",        32'h00800000, 32'h00800000, 32'h00000000, 4'b0011};
    vecs[4]  = '{"inf_x_0",    32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
    vecs[5]  = '{"ninf_x_1",   32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000};
    vecs[6]  = '{"nan_x_1",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000};
    vecs[7]  = '{"nzero_x_1",  32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000};
    vecs[8]  = '{"denorm",     32'h00000001, 32'hBF800000, 32'h80000000, 4'b0000};
    vecs[9]  = '{"max_exact",  32'h7F000000, 32'h3FFFFFFF, 32'h7F7FFFFF, 4'b0000};
    vecs[10] = '{"ovf_edge",   32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101};
    vecs[11] = '{"unf_edge",   32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011};
    vecs[12] = '{"min_norm",   32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000};
    vecs[13] = '{"inexact",    32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001};
    vecs[14] = '{"neg_3x3",    32'hC0400000, 32'h40400000, 32'hC1100000, 4'b0000};
    vecs[15] = '{"0_x_ninf",   32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    #2;
    check("reset.in_ready",   32'(in_ready),   32'd1);
    check("reset.out_valid",  32'(out_valid),  32'd0);
    check("reset.busy",       32'(busy),       32'd0);
    check("reset.out_result", out_result,      32'd0);
    check("reset.out_flags",  32'(out_flags),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags);
    end

    // Backpressure: result held for 10 stalled cycles, new operands refused.
    @(negedge clk);
    in_a     = 32'h3FC00000;
    in_b     = 32'h40000000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(cycles);
    check("stall.latency", 32'(cycles), 32'(LATENCY));
    for (int k = 0; k < 10; k++) begin
      in_a     = 32'h3F800000;
      in_b     = 32'h3F800000;
      in_valid = 1'b1;
      @(negedge clk);
      check("stall.out_valid", 32'(out_valid), 32'd1);
      check("stall.result",    out_result,     32'h40400000);
      check("stall.flags",     32'(out_flags), 32'd0);
      check("stall.in_ready",  32'(in_ready),  32'd0);
    end
    $display("op %-12s held result=%h for 10 stalled cycles", "stall", out_result);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall.release_valid", 32'(out_valid), 32'd0);
    check("stall.release_ready", 32'(in_ready),  32'd1);
    check("stall.release_busy",  32'(busy),      32'd0);

    // Asynchronous reset in the middle of the mantissa loop.
    @(negedge clk);
    in_a     = 32'h40400000;
    in_b     = 32'h40400000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (13) @(negedge clk);
    check("abort.busy_before", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort.in_ready",   32'(in_ready),  32'd1);
    check("abort.out_valid",  32'(out_valid), 32'd0);
    check("abort.busy",       32'(busy),      32'd0);
    check("abort.out_result", out_result,     32'd0);
    check("abort.out_flags",  32'(out_flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1 || busy === 1'b1) seen_valid++;
    end
    check("abort.no_result", 32'(seen_valid), 32'd0);
    $display("op %-12s reset mid-MANT, idle cycles afterwards=40", "abort");
    run_op("one_x_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
